// File: rtl/ghost_collision_monitor_pkg.sv
// Shared playfield geometry and state encoding for the ghost collision monitor.
package ghost_collision_monitor_pkg;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  typedef enum logic [2:0] {
    CM_PLAY    = 3'd0,
    CM_HIT     = 3'd1,
    CM_RESPAWN = 3'd2,
    CM_GRACE   = 3'd3,
    CM_OVER    = 3'd4
  } cm_state_e;

endpackage

// File: rtl/ghost_collision_monitor_pos_tracker.sv
// Remembers the previous tile of one mover and how long ago it last changed tile.
module pos_tracker #(
  parameter int W           = 19,
  parameter int SWAP_WINDOW = 17,
  parameter int AW          = $clog2(SWAP_WINDOW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  pos,
  output logic [W-1:0]  prev,
  output logic [AW-1:0] age
);

  logic [W-1:0] last;

  // Age saturates at the window so a stale move can never look like a crossing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= pos;
      prev <= pos;
      age  <= AW'(SWAP_WINDOW);
    end else if (pos != last) begin
      prev <= last;
      last <= pos;
      age  <= '0;
    end else if (age < AW'(SWAP_WINDOW)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/ghost_collision_monitor.sv
// Detects ghost/player overlap or tile swap and sequences freeze, respawn and grace.
//   state   | meaning
//   PLAY    | normal play, collisions evaluated
//   HIT     | playfield frozen after a hit
//   RESPAWN | one-cycle respawn pulse
//   GRACE   | movers run, collisions ignored
//   OVER    | no lives left, frozen until reset
module ghost_collision_monitor
  import ghost_collision_monitor_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int START_LIVES   = 3,
  parameter int FREEZE_CYCLES = 64,
  parameter int GRACE_CYCLES  = 34,
  parameter int SWAP_WINDOW   = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XW-1:0]            player_x,
  input  logic [YW-1:0]            player_y,
  input  logic [NUM_GHOSTS*XW-1:0] ghost_x,
  input  logic [NUM_GHOSTS*YW-1:0] ghost_y,
  output logic                     freeze,
  output logic                     respawn,
  output logic                     hit_valid,
  output logic [1:0]               hit_id,
  output logic [1:0]               lives,
  output logic                     game_over
);

  localparam int PW   = XW + YW;
  localparam int AW   = $clog2(SWAP_WINDOW + 1);
  localparam int CMAX = (FREEZE_CYCLES > GRACE_CYCLES) ? FREEZE_CYCLES : GRACE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [PW-1:0] ppos, p_prev;
  logic [AW-1:0] p_age;
  logic [PW-1:0] gpos   [NUM_GHOSTS];
  logic [PW-1:0] g_prev [NUM_GHOSTS];
  logic [AW-1:0] g_age  [NUM_GHOSTS];

  assign ppos = {player_y, player_x};

  pos_tracker #(.W(PW), .SWAP_WINDOW(SWAP_WINDOW), .AW(AW)) u_player_trk (
    .clk(clk), .reset(reset), .pos(ppos), .prev(p_prev), .age(p_age)
  );

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    assign gpos[g] = {ghost_y[g*YW +: YW], ghost_x[g*XW +: XW]};
    pos_tracker #(.W(PW), .SWAP_WINDOW(SWAP_WINDOW), .AW(AW)) u_ghost_trk (
      .clk(clk), .reset(reset), .pos(gpos[g]), .prev(g_prev[g]), .age(g_age[g])
    );
  end

  logic       hit_any;
  logic [1:0] hit_idx;

  // Scanning downward leaves the lowest-index hitter in hit_idx.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if ((gpos[i] == ppos) ||
          ((gpos[i] == p_prev) && (g_prev[i] == ppos) &&
           (g_age[i] < AW'(SWAP_WINDOW)) && (p_age < AW'(SWAP_WINDOW)))) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  cm_state_e     state, state_nx;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CM_PLAY;
      cnt       <= '0;
      lives     <= 2'(START_LIVES);
      hit_id    <= '0;
      hit_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      hit_valid <= 1'b0;
      if (state == CM_PLAY && hit_any) begin
        hit_valid <= 1'b1;
        hit_id    <= hit_idx;
        lives     <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
        cnt       <= CW'(FREEZE_CYCLES - 1);
      end else if (state == CM_RESPAWN) begin
        cnt <= CW'(GRACE_CYCLES - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CM_PLAY:    if (hit_any) state_nx = CM_HIT;
      CM_HIT:     if (cnt == '0) state_nx = (lives == 2'd0) ? CM_OVER : CM_RESPAWN;
      CM_RESPAWN: state_nx = CM_GRACE;
      CM_GRACE:   if (cnt == '0) state_nx = CM_PLAY;
      CM_OVER:    state_nx = CM_OVER;
      default:    state_nx = CM_PLAY;
    endcase
  end

  always_comb begin
    freeze    = (state == CM_HIT) || (state == CM_RESPAWN) || (state == CM_OVER);
    respawn   = (state == CM_RESPAWN);
    game_over = (state == CM_OVER);
  end

endmodule

// File: tb/tb_ghost_collision_monitor.sv
// Directed bench for ghost_collision_monitor with a queue of expected hit events.
module tb_ghost_collision_monitor;
  import ghost_collision_monitor_pkg::*;

  localparam int NG = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [XW-1:0]      player_x;
  logic [YW-1:0]      player_y;
  logic [NG*XW-1:0]   ghost_x;
  logic [NG*YW-1:0]   ghost_y;
  logic               freeze, respawn, hit_valid, game_over;
  logic [1:0]         hit_id, lives;

  ghost_collision_monitor #(
    .NUM_GHOSTS(NG), .START_LIVES(3), .FREEZE_CYCLES(64),
    .GRACE_CYCLES(34), .SWAP_WINDOW(17)
  ) dut (
    .clk(clk), .reset(reset), .player_x(player_x), .player_y(player_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .freeze(freeze), .respawn(respawn),
    .hit_valid(hit_valid), .hit_id(hit_id), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int id;
    int lv;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Advance one cycle, then match hit_valid against the expected-hit queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("hit_valid", 32'(hit_valid), 32'd1);
      chk("hit_id", 32'(hit_id), 32'(e.id));
      chk("hit_lives", 32'(lives), 32'(e.lv));
    end else begin
      chk("no_hit", 32'(hit_valid), 32'd0);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_x[i*XW +: XW] = XW'(x);
    ghost_y[i*YW +: YW] = YW'(y);
  endtask

  task automatic set_player(input int x, input int y);
    player_x = XW'(x);
    player_y = YW'(y);
  endtask

  task automatic home_ghosts();
    set_ghost(0, 20, 20);
    set_ghost(1, 40, 40);
    set_ghost(2, 60, 60);
    set_ghost(3, 80, 80);
  endtask

  task automatic chk_reset_values();
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_respawn", 32'(respawn), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_hit_id", 32'(hit_id), 32'd0);
  endtask

  int c_a, s_b, h_b, h_c, x_d;

  initial begin
    reset = 1'b0;
    ghost_x = '0;
    ghost_y = '0;
    set_player(300, 240);
    home_ghosts();
    run(2);
    chk_reset_values();
    reset = 1'b1;
    run(100);
    chk("idle_freeze", 32'(freeze), 32'd0);
    chk("idle_lives", 32'(lives), 32'd3);

    // Overlap by ghost 2, with a crossing staged 20 cycles apart during the freeze.
    c_a = cyc;
    set_ghost(2, 300, 240);
    exp_q.push_back('{c_a + 1, 2, 2});
    step();
    chk("a_freeze_start", 32'(freeze), 32'd1);
    set_ghost(2, 60, 60);
    set_ghost(0, 320, 240);
    wait_until(c_a + 5);
    set_player(320, 240);
    wait_until(c_a + 25);
    set_ghost(0, 300, 240);
    wait_until(c_a + 64);
    chk("a_freeze_end", 32'(freeze), 32'd1);
    chk("a_no_early_respawn", 32'(respawn), 32'd0);
    step();
    chk("a_respawn", 32'(respawn), 32'd1);
    chk("a_respawn_freeze", 32'(freeze), 32'd1);
    step();
    chk("a_respawn_end", 32'(respawn), 32'd0);
    chk("a_grace_freeze", 32'(freeze), 32'd0);
    wait_until(c_a + 90);
    set_ghost(1, 320, 240);
    wait_until(c_a + 99);
    set_ghost(1, 40, 40);
    run(21);
    chk("a_lives", 32'(lives), 32'd2);

    // Simultaneous tile swap between player and ghost 0.
    set_player(280, 20);
    set_ghost(0, 300, 20);
    run(20);
    s_b = cyc;
    set_player(300, 20);
    set_ghost(0, 280, 20);
    h_b = s_b + 2;
    exp_q.push_back('{h_b, 0, 1});
    wait_until(h_b);
    chk("b_freeze", 32'(freeze), 32'd1);

    // Ghosts 1 and 3 overlap from the last grace cycle on: one hit, id 1.
    wait_until(h_b + 98);
    set_ghost(1, 300, 20);
    set_ghost(3, 300, 20);
    h_c = h_b + 100;
    exp_q.push_back('{h_c, 1, 0});
    wait_until(h_c + 63);
    chk("c_freeze", 32'(freeze), 32'd1);
    chk("c_not_over_yet", 32'(game_over), 32'd0);
    step();
    chk("c_game_over", 32'(game_over), 32'd1);
    set_ghost(2, 300, 20);
    for (int k = 0; k < 30; k++) begin
      chk("over_respawn", 32'(respawn), 32'd0);
      chk("over_freeze", 32'(freeze), 32'd1);
      chk("over_game_over", 32'(game_over), 32'd1);
      chk("over_lives", 32'(lives), 32'd0);
      step();
    end

    // Reset out of OVER.
    reset = 1'b0;
    set_player(300, 240);
    home_ghosts();
    step();
    chk_reset_values();
    reset = 1'b1;
    run(5);

    // Reset in the 30th freeze cycle of a fresh hit.
    x_d = cyc;
    set_ghost(2, 300, 240);
    exp_q.push_back('{x_d + 1, 2, 2});
    wait_until(x_d + 30);
    chk("d_freeze", 32'(freeze), 32'd1);
    reset = 1'b0;
    set_ghost(2, 60, 60);
    step();
    chk_reset_values();
    reset = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step();
      chk("d_no_respawn", 32'(respawn), 32'd0);
      chk("d_no_freeze", 32'(freeze), 32'd0);
    end
    chk("pending_hits", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost_collision_monitor.md
Name: ghost_collision_monitor

Overview:
- Consumes the position/direction interface driven by the ghost controllers and the player controller.
- Each cycle it checks whether any ghost occupies, or has just swapped tiles with, the player.
- It sequences the resulting death: freeze, life decrement, respawn pulse, then a grace window.
- It sits between the movement controllers and the game/top-level FSM. Its respawn pulse re-initialises the movers.

Parameters:
- NUM_GHOSTS, 4, number of ghost position inputs.
- START_LIVES, 3, lives loaded at reset (1..3).
- FREEZE_CYCLES, 64, cycles the playfield stays frozen after a hit.
- GRACE_CYCLES, 34, cycles after respawn during which collisions are ignored.
- SWAP_WINDOW, 17, maximum age in cycles of a position change for it to count in swap (crossing) detection.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- player_x  in  $clog2(`WIDTH)  player pixel x, tile-aligned
- player_y  in  $clog2(`HEIGHT)  player pixel y, tile-aligned
- ghost_x  in  NUM_GHOSTS*$clog2(`WIDTH)  packed ghost x; ghost i occupies slice i
- ghost_y  in  NUM_GHOSTS*$clog2(`HEIGHT)  packed ghost y
- freeze  out  1  high = movers must hold position
- respawn  out  1  one-cycle pulse; movers reload their start positions
- hit_valid  out  1  one-cycle pulse on each registered hit
- hit_id  out  2  index of the ghost that caused the last hit
- lives  out  2  remaining lives
- game_over  out  1  sticky until reset

Behaviour:
- Reset applies only on a clk edge with reset==0:
  - state=PLAY, lives=START_LIVES; freeze, respawn, hit_valid, game_over and hit_id all 0.
  - Each tracker's last and prev registers are loaded with the current input position. Age counters saturate at SWAP_WINDOW (no swap possible).
- Position tracker (player and each ghost), every cycle:
  - If the input differs from last: prev<=last, last<=input, age<=0.
  - Otherwise age increments, saturating at SWAP_WINDOW.
- Overlap(i): ghost i x and y both equal player x and y (current inputs; exact equality, since positions are tile multiples).
- Swap(i): all of the following hold:
  - ghost_i current == player prev;
  - ghost_i prev == player current;
  - both ages < SWAP_WINDOW.
- hit_any = OR over i of (Overlap(i) | Swap(i)). This is combinational from the current inputs and the tracker registers.
- Several ghosts hitting in the same cycle count as one hit; hit_id = lowest index.
- FSM states: PLAY, HIT, RESPAWN, GRACE, OVER.
- PLAY:
  - If hit_any is true in cycle N, then in cycle N+1: state=HIT, hit_valid=1 (one cycle), hit_id latched, lives decremented, freeze=1.
- HIT:
  - freeze=1; a counter runs FREEZE_CYCLES cycles, counting the entry cycle.
  - When the counter expires: if lives==0 go to OVER, else go to RESPAWN.
- RESPAWN: single cycle; respawn=1, freeze=1; next state GRACE.
- GRACE:
  - freeze=0; hit_any is ignored and the trackers keep updating.
  - After GRACE_CYCLES cycles, go to PLAY.
- OVER: freeze=1, game_over=1; absorbing until reset.
- Lives never underflow; decrement happens only on PLAY->HIT.
- A reset in any state, including mid-freeze and OVER, restores the reset values on that edge. No respawn pulse is emitted on reset.
- Swap detection also fires in GRACE's last cycle only if the hit is evaluated in PLAY; hits are evaluated only while in PLAY.

Decomposition:
- define.v already supplies `WIDTH, `HEIGHT and the direction macros.
- Add state encodings `cm_play, `cm_hit, `cm_respawn, `cm_grace and `cm_over to define.v.
- One sub-module is natural: pos_tracker (parameter widths; outputs last, prev, age). Instantiate it once for the player and NUM_GHOSTS times in a generate loop.

Test Plan:
- Reset with player (300,240), ghosts elsewhere, lives expected 3 -> all outputs at reset values; no hit for 100 cycles.
- Ghost 2 set to (300,240) at cycle 10 -> hit_valid pulse cycle 11, hit_id=2, lives=2, freeze high cycles 11..74, respawn pulse cycle 75, freeze low cycle 76, no hit honoured until cycle 110.
- Player (280,20)->(300,20) and ghost 0 (300,20)->(280,20) on the same cycle, never overlapping -> swap hit the next cycle, hit_id=0. Repeat with the ghost move 20 cycles later -> no hit.
- Ghosts 1 and 3 overlap the player on the same cycle -> a single hit_valid, hit_id=1, lives decremented once.
- Three consecutive hits from START_LIVES=3 -> after the third freeze, game_over=1, freeze stays 1, no respawn pulse; further overlaps are ignored and lives stays 0.
- Reset asserted at cycle 30 of a freeze -> the next edge gives lives=3, freeze=0, state PLAY; no respawn pulse.
